// File: rtl/forwarding_hazard_unit.sv
// Decode-stage forwarding, load-use stall and branch-flag unit for the 5-stage LEGv8 pipeline.
// Define FWD_STATS_EN to build the saturating stall/forward statistics counters.
module forwarding_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int FLAG_W     = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_dec,
  input  logic [FLAG_W-1:0] alu_flags_ex,
  output logic [1:0]        FW_RegFile1_Ctrl,
  output logic [1:0]        FW_RegFile2_Ctrl,
  output logic              stall_dec,
  output logic [FLAG_W-1:0] flags_dec,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  fwd_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  localparam logic [REG_ADDR_W-1:0] XZR = {REG_ADDR_W{1'b1}};
  localparam logic [REG_ADDR_W-1:0] LR  = REG_ADDR_W'(30);

  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_BR   = 11'b11010110000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_BLT  = 8'b01010100;
  localparam logic [5:0]  OP_BL   = 6'b100101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
    logic                  sets_flags;
  } slot_t;

  slot_t                 dec_slot;
  slot_t                 ex_q, ex_d;
  slot_t                 mem_q, mem_d;
  logic [FLAG_W-1:0]     flag_q, flag_d;
  logic                  uses_a, uses_b;
  logic [REG_ADDR_W-1:0] ra, rb;
  logic [1:0]            sel_a, sel_b;
  logic                  ex_sets_flags;
  logic                  unused_instr_bits;

  // Immediate/shamt bits never name a register.
  assign unused_instr_bits = ^instr_dec[15:10];

  always_comb begin
    dec_slot    = '0;
    dec_slot.rd = REG_ADDR_W'(instr_dec[4:0]);
    uses_a      = 1'b0;
    uses_b      = 1'b0;
    ra          = REG_ADDR_W'(instr_dec[9:5]);
    rb          = REG_ADDR_W'(instr_dec[20:16]);
    if (instr_dec[31:22] == OP_ADDI) begin
      dec_slot.valid = 1'b1;
      dec_slot.wr    = 1'b1;
      uses_a         = 1'b1;
    end else if (instr_dec[31:21] == OP_ADDS || instr_dec[31:21] == OP_SUBS) begin
      dec_slot.valid      = 1'b1;
      dec_slot.wr         = 1'b1;
      dec_slot.sets_flags = 1'b1;
      uses_a              = 1'b1;
      uses_b              = 1'b1;
    end else if (instr_dec[31:21] == OP_AND || instr_dec[31:21] == OP_EOR) begin
      dec_slot.valid = 1'b1;
      dec_slot.wr    = 1'b1;
      uses_a         = 1'b1;
      uses_b         = 1'b1;
    end else if (instr_dec[31:21] == OP_LSR) begin
      dec_slot.valid = 1'b1;
      dec_slot.wr    = 1'b1;
      uses_a         = 1'b1;
    end else if (instr_dec[31:21] == OP_LDUR) begin
      dec_slot.valid   = 1'b1;
      dec_slot.wr      = 1'b1;
      dec_slot.is_load = 1'b1;
      uses_a           = 1'b1;
    end else if (instr_dec[31:21] == OP_STUR) begin
      // Store data register lives in the Rt field, not Rm.
      dec_slot.valid = 1'b1;
      uses_a         = 1'b1;
      uses_b         = 1'b1;
      rb             = REG_ADDR_W'(instr_dec[4:0]);
    end else if (instr_dec[31:21] == OP_BR) begin
      dec_slot.valid = 1'b1;
      uses_a         = 1'b1;
    end else if (instr_dec[31:24] == OP_CBZ) begin
      dec_slot.valid = 1'b1;
      uses_b         = 1'b1;
      rb             = REG_ADDR_W'(instr_dec[4:0]);
    end else if (instr_dec[31:24] == OP_BLT) begin
      dec_slot.valid = 1'b1;
    end else if (instr_dec[31:26] == OP_BL) begin
      dec_slot.valid = 1'b1;
      dec_slot.wr    = 1'b1;
      dec_slot.rd    = LR;
    end else if (instr_dec[31:26] == OP_B) begin
      dec_slot.valid = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic                  used,
                                         input logic [REG_ADDR_W-1:0] r,
                                         input slot_t                 ex,
                                         input slot_t                 mem);
    logic [1:0] s;
    s = SEL_RF;
    if (used && r != XZR) begin
      if (ex.valid && ex.wr && ex.rd == r)
        s = SEL_EX;
      else if (mem.valid && mem.wr && mem.rd == r)
        s = SEL_MEM;
    end
    return s;
  endfunction

  assign sel_a = fwd_sel(uses_a, ra, ex_q, mem_q);
  assign sel_b = fwd_sel(uses_b, rb, ex_q, mem_q);

  assign stall_dec = ex_q.valid && ex_q.is_load &&
                     ((uses_a && ra != XZR && ra == ex_q.rd) ||
                      (uses_b && rb != XZR && rb == ex_q.rd));

  assign FW_RegFile1_Ctrl = stall_dec ? SEL_RF : sel_a;
  assign FW_RegFile2_Ctrl = stall_dec ? SEL_RF : sel_b;

  // Flags from a flag-setter in EX bypass the committed register.
  assign ex_sets_flags = ex_q.valid && ex_q.sets_flags;
  assign flag_d        = ex_sets_flags ? alu_flags_ex : flag_q;
  assign flags_dec     = flag_d;

  assign ex_d  = stall_dec ? slot_t'('0) : dec_slot;
  assign mem_d = ex_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q   <= '0;
      mem_q  <= '0;
      flag_q <= '0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      flag_q <= flag_d;
    end
  end

`ifdef FWD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [1:0]       fwd_inc;

  always_comb begin
    fwd_inc     = {1'b0, |FW_RegFile1_Ctrl} + {1'b0, |FW_RegFile2_Ctrl};
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_dec) begin
      if (stall_cnt_q != CNT_MAX)
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (fwd_inc != 2'd0) begin
      if (fwd_cnt_q > CNT_MAX - CNT_W'(fwd_inc))
        fwd_cnt_d = CNT_MAX;
      else
        fwd_cnt_d = fwd_cnt_q + CNT_W'(fwd_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign fwd_count   = fwd_cnt_q;
`else
  assign stall_count = '0;
  assign fwd_count   = '0;
`endif

endmodule
